// File: rtl/spram_arbiter.sv
// Single-port RAM front-end: strict-priority read port A, read/write port B,
// and a clear engine that fills the whole RAM after reset or on command.
module spram_arbiter #(
  parameter int address_width = 10,
  parameter int data_width    = 8,
  parameter int clear_value   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_start,
  output logic                     clear_busy,
  input  logic                     a_req,
  input  logic [address_width-1:0] a_addr,
  output logic                     a_valid,
  output logic [data_width-1:0]    a_q,
  input  logic                     b_req,
  input  logic                     b_wr,
  input  logic [address_width-1:0] b_addr,
  input  logic [data_width-1:0]    b_data,
  output logic                     b_ack,
  output logic [data_width-1:0]    b_q,
  output logic                     ram_wren,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  input  logic [data_width-1:0]    ram_q
);

  localparam logic [data_width-1:0] CLR_WORD = data_width'(clear_value);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state, state_nx;
  logic [address_width-1:0] cnt, cnt_nx, last_addr;
  logic                     a_gnt, b_gnt, b_pend;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    ram_wren    = 1'b0;
    ram_address = last_addr;
    ram_data    = b_data;
    case (state)
      CLEAR: begin
        ram_address = cnt;
        ram_data    = CLR_WORD;
        ram_wren    = 1'b1;
        cnt_nx      = cnt + 1'b1;
        if (cnt == '1) state_nx = RUN;
      end
      RUN: begin
        if (a_req) begin
          a_gnt       = 1'b1;
          ram_address = a_addr;
        // b_pend is still set in the ack cycle, so one request yields one access
        end else if (b_req && !b_pend) begin
          b_gnt       = 1'b1;
          ram_address = b_addr;
          ram_wren    = b_wr;
        end
        if (clear_start) state_nx = CLEAR;
      end
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= '0;
      a_valid   <= 1'b0;
      b_ack     <= 1'b0;
      b_pend    <= 1'b0;
      last_addr <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      a_valid <= a_gnt;
      b_ack   <= b_gnt;
      if (b_gnt)      b_pend <= 1'b1;
      else if (b_ack) b_pend <= 1'b0;
      if (a_gnt || b_gnt) last_addr <= ram_address;
    end
  end

  // Strobes qualify the raw RAM output; no path from ram_q into control.
  assign clear_busy = (state == CLEAR);
  assign a_q        = ram_q;
  assign b_q        = ram_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter (address_width=4) with a behavioural
// read-before-write single-port RAM attached to the RAM-side ports.
module tb_spram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset, clear_start, clear_busy;
  logic          a_req, a_valid, b_req, b_wr, b_ack, ram_wren;
  logic [AW-1:0] a_addr, b_addr, ram_address;
  logic [DW-1:0] a_q, b_q, b_data, ram_data, ram_q;

  int checks = 0;
  int failures = 0;

  spram_arbiter #(.address_width(AW), .data_width(DW), .clear_value(0)) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .a_req(a_req), .a_addr(a_addr), .a_valid(a_valid), .a_q(a_q),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_data(b_data),
    .b_ack(b_ack), .b_q(b_q),
    .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] <= ram_data;
  end

  typedef struct {
    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          b_req;
    logic          b_wr;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          e_wren;
    logic [AW-1:0] e_addr;
    logic          e_av;
    logic          e_bk;
    logic [DW-1:0] e_q;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 8'h5A, 1'b1, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h3, 8'h5A, 1'b0, 4'h3, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 8'h5A};
    tbl[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 4'h3, 1'b1, 1'b0, 8'h5A};
    tbl[7]  = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 4'h3, 1'b1, 1'b0, 8'h5A};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b1, 4'h7, 1'b1, 1'b0, 8'h5A};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h7, 8'hA5, 1'b0, 4'h7, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{1'b1, 4'h7, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h7, 1'b1, 1'b0, 8'hA5};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 8'h5A};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h7, 8'h00, 1'b0, 4'h7, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h7, 1'b0, 1'b1, 8'hA5};
    tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 4'h3, 1'b0, 1'b1, 8'h5A};
    tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h3, 1'b0, 1'b0, 8'h00};

    reset = 1'b1; clear_start = 1'b0;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_data = '0;

    // reset held two cycles, then the power-on clear
    nxt();
    @(negedge clock);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_busy", clear_busy, 1);
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("clr_busy", clear_busy, 1);
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_address, i);
      chk("clr_data", ram_data, 0);
      nxt();
    end

    // read back every location through port A
    for (int i = 0; i < 16; i++) begin
      a_req = 1'b1; a_addr = AW'(i);
      @(negedge clock);
      if (i == 0) chk("run_busy", clear_busy, 0);
      else begin
        chk("rd_a_valid", a_valid, 1);
        chk("rd_a_q", a_q, 0);
      end
      chk("rd_addr", ram_address, i);
      nxt();
    end
    a_req = 1'b0;
    @(negedge clock);
    chk("rd_a_valid_last", a_valid, 1);
    chk("rd_a_q_last", a_q, 0);
    nxt();

    // table: B write/read, A over B priority, back-to-back B rate
    for (int r = 0; r < 19; r++) begin
      a_req = tbl[r].a_req; a_addr = tbl[r].a_addr;
      b_req = tbl[r].b_req; b_wr = tbl[r].b_wr;
      b_addr = tbl[r].b_addr; b_data = tbl[r].b_data;
      @(negedge clock);
      chk($sformatf("tbl%0d_wren", r), ram_wren, tbl[r].e_wren);
      chk($sformatf("tbl%0d_addr", r), ram_address, tbl[r].e_addr);
      chk($sformatf("tbl%0d_a_valid", r), a_valid, tbl[r].e_av);
      chk($sformatf("tbl%0d_b_ack", r), b_ack, tbl[r].e_bk);
      if (tbl[r].e_wren) chk($sformatf("tbl%0d_data", r), ram_data, tbl[r].b_data);
      if (tbl[r].e_av) chk($sformatf("tbl%0d_a_q", r), a_q, tbl[r].e_q);
      if (tbl[r].e_bk) chk($sformatf("tbl%0d_b_q", r), b_q, tbl[r].e_q);
      nxt();
    end

    // clear_start together with a granted B write
    b_req = 1'b1; b_wr = 1'b1; b_addr = 4'h2; b_data = 8'h11; clear_start = 1'b1;
    @(negedge clock);
    chk("cs_wren", ram_wren, 1);
    chk("cs_addr", ram_address, 2);
    nxt();
    clear_start = 1'b0;
    @(negedge clock);
    chk("cs_b_ack", b_ack, 1);
    chk("cs_b_q", b_q, 0);
    nxt();
    b_req = 1'b0; b_wr = 1'b0;
    a_req = 1'b1; a_addr = 4'h2;
    for (int i = 1; i < 16; i++) begin
      @(negedge clock);
      chk("cs_busy", clear_busy, 1);
      chk("cs_clr_addr", ram_address, i);
      chk("cs_no_a_valid", a_valid, 0);
      chk("cs_no_b_ack", b_ack, 0);
      nxt();
    end
    @(negedge clock);
    chk("cs_done_busy", clear_busy, 0);
    chk("cs_a_grant_addr", ram_address, 2);
    chk("cs_a_grant_wren", ram_wren, 0);
    chk("cs_no_a_valid_yet", a_valid, 0);
    nxt();
    a_req = 1'b0;
    @(negedge clock);
    chk("cs_rd_a_valid", a_valid, 1);
    chk("cs_rd_a_q", a_q, 0);
    nxt();

    // reset in the middle of a clear restarts it at address 0
    clear_start = 1'b1;
    nxt();
    clear_start = 1'b0;
    repeat (9) nxt();
    reset = 1'b1;
    @(negedge clock);
    chk("mid_addr9", ram_address, 9);
    nxt();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      chk("rc_busy", clear_busy, 1);
      chk("rc_wren", ram_wren, 1);
      chk("rc_addr", ram_address, i);
      nxt();
    end
    @(negedge clock);
    chk("rc_done_busy", clear_busy, 0);
    chk("rc_done_wren", ram_wren, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
